// File: rtl/dahb_lsu_ctrl.sv
// Load/store front-end between the core memory stage and the DAHB master:
// pushes aligned requests into the transaction buffer, stalls for loads and extends load data.
module dahb_lsu_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TMR_WIDTH      = 10
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_reset,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [2:0]            mem_funct3,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_stall,
   output logic [DATA_WIDTH-1:0] load_rdata,
   output logic                  load_rdata_valid,
   output logic                  load_fault,
   output logic                  misalign_err,
   output logic                  DAHB_access,
   output logic [2:0]            DAHB_size,
   output logic                  DAHB_rd0_wr1,
   output logic [DATA_WIDTH-1:0] DAHB_write_data,
   output logic [ADDR_WIDTH-1:0] DAHB_addr,
   input  logic                  DAHB_trans_buffer_full,
   input  logic [DATA_WIDTH-1:0] DAHB_read_data,
   input  logic                  DAHB_read_data_valid
);

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, RESP} state_t;

   state_t                state;
   logic [1:0]            lane;
   logic [2:0]            funct3_q;
   logic [TMR_WIDTH-1:0]  timer;
   logic                  fault;
   logic                  misaligned;
   logic                  idle_req;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_WIDTH-1:0] load_ext;

   // Unknown funct3 encodings fall into the misaligned path so they are dropped.
   always_comb begin
      misaligned = 1'b1;
      case (mem_funct3)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = mem_addr[0];
         3'b010:         misaligned = |mem_addr[1:0];
         default:        misaligned = 1'b1;
      endcase
   end

   assign idle_req     = (state == IDLE) && mem_req;
   assign misalign_err = idle_req && misaligned;
   assign DAHB_access  = idle_req && !misaligned && !DAHB_trans_buffer_full;
   assign mem_stall    = (state == WAIT_LOAD) ||
                         (idle_req && !misaligned && (DAHB_trans_buffer_full || !mem_we));

   assign DAHB_size    = {1'b0, mem_funct3[1:0]};
   assign DAHB_rd0_wr1 = mem_we;
   assign DAHB_addr    = mem_addr;

   always_comb begin
      DAHB_write_data = '0;
      if (mem_we) begin
         case (mem_funct3[1:0])
            2'b00:   DAHB_write_data = {4{mem_wdata[7:0]}};
            2'b01:   DAHB_write_data = {2{mem_wdata[15:0]}};
            default: DAHB_write_data = mem_wdata;
         endcase
      end
   end

   assign rd_byte = DAHB_read_data[{lane, 3'b000} +: 8];
   assign rd_half = DAHB_read_data[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_ext = DAHB_read_data;
      case (funct3_q[1:0])
         2'b00:   load_ext = {{(DATA_WIDTH-8){!funct3_q[2] && rd_byte[7]}}, rd_byte};
         2'b01:   load_ext = {{(DATA_WIDTH-16){!funct3_q[2] && rd_half[15]}}, rd_half};
         default: load_ext = DAHB_read_data;
      endcase
   end

   assign load_rdata_valid = (state == RESP) && !fault;
   assign load_fault       = (state == RESP) && fault;

   always_ff @(posedge cpu_clk or posedge cpu_reset) begin
      if (cpu_reset) begin
         state      <= IDLE;
         timer      <= '0;
         load_rdata <= '0;
         lane       <= '0;
         funct3_q   <= '0;
         fault      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fault <= 1'b0;
               if (DAHB_access && !mem_we) begin
                  lane     <= mem_addr[1:0];
                  funct3_q <= mem_funct3;
                  timer    <= '0;
                  state    <= WAIT_LOAD;
               end
            end
            WAIT_LOAD: begin
               timer <= timer + 1'b1;
               // Data arriving on the final timeout cycle still wins over the fault.
               if (DAHB_read_data_valid) begin
                  load_rdata <= load_ext;
                  fault      <= 1'b0;
                  state      <= RESP;
               end else if (timer == TMR_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                  load_rdata <= '0;
                  fault      <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dahb_lsu_ctrl.sv
// Bench for dahb_lsu_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a transaction-level model.
module tb_dahb_lsu_ctrl;
   localparam int T = 8;

   logic        cpu_clk, cpu_reset;
   logic        mem_req, mem_we;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_stall, load_rdata_valid, load_fault, misalign_err;
   logic [31:0] load_rdata;
   logic        DAHB_access, DAHB_rd0_wr1;
   logic [2:0]  DAHB_size;
   logic [31:0] DAHB_write_data, DAHB_addr;
   logic        DAHB_trans_buffer_full, DAHB_read_data_valid;
   logic [31:0] DAHB_read_data;

   dahb_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .TMR_WIDTH(10)) dut (
      .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
      .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .load_rdata(load_rdata),
      .load_rdata_valid(load_rdata_valid), .load_fault(load_fault),
      .misalign_err(misalign_err), .DAHB_access(DAHB_access),
      .DAHB_size(DAHB_size), .DAHB_rd0_wr1(DAHB_rd0_wr1),
      .DAHB_write_data(DAHB_write_data), .DAHB_addr(DAHB_addr),
      .DAHB_trans_buffer_full(DAHB_trans_buffer_full),
      .DAHB_read_data(DAHB_read_data), .DAHB_read_data_valid(DAHB_read_data_valid)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int total = 0;
   int bad   = 0;

   // Model: one outstanding load (with its waited-cycle count) and one pending response.
   bit          m_load, m_resp, m_rfault;
   int          m_wait;
   bit [1:0]    m_lane;
   bit [2:0]    m_f3;
   logic [31:0] m_rdata;
   bit          prev_stall;

   logic        o_stall, o_access, o_valid, o_fault, o_mis;
   logic [31:0] o_rdata, o_wdata;
   logic [2:0]  o_size;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] extract(input bit [2:0] f3, input bit [1:0] a, input logic [31:0] d);
      int v;
      if (f3[1:0] == 2'd0) begin
         v = int'((d >> (8 * a)) & 32'hFF);
         if (!f3[2] && v >= 128) v -= 256;
      end else if (f3[1:0] == 2'd1) begin
         v = int'((d >> (16 * a[1])) & 32'hFFFF);
         if (!f3[2] && v >= 32768) v -= 65536;
      end else begin
         v = int'(d);
      end
      return 32'(v);
   endfunction

   function automatic bit misal(input bit [2:0] f3, input bit [31:0] ad);
      case (f3)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return ad[0];
         3'd2:       return ad[1:0] != 2'd0;
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] lanes(input bit [2:0] f3, input logic [31:0] w);
      if (f3[1:0] == 2'd0) return (w & 32'hFF) * 32'h01010101;
      if (f3[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   task automatic step(input bit req, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input bit full, input bit rv, input bit [31:0] rd);
      bit          e_stall, e_acc, e_mis, e_val, e_flt;
      logic [31:0] e_rd;
      @(negedge cpu_clk);
      mem_req = req; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
      DAHB_trans_buffer_full = full; DAHB_read_data_valid = rv; DAHB_read_data = rd;
      #1;
      e_stall = 0; e_acc = 0; e_mis = 0; e_val = 0; e_flt = 0; e_rd = '0;
      if (m_resp) begin
         e_val = !m_rfault; e_flt = m_rfault; e_rd = m_rfault ? 32'h0 : m_rdata;
         m_resp = 0;
      end else if (m_load) begin
         e_stall = 1;
         m_wait++;
         if (rv) begin
            m_resp = 1; m_rfault = 0; m_rdata = extract(m_f3, m_lane, rd); m_load = 0;
         end else if (m_wait == T) begin
            m_resp = 1; m_rfault = 1; m_load = 0;
         end
      end else if (req) begin
         if (misal(f3, addr)) e_mis = 1;
         else if (full) e_stall = 1;
         else begin
            e_acc = 1; e_stall = !we;
            if (!we) begin m_load = 1; m_wait = 0; m_lane = addr[1:0]; m_f3 = f3; end
         end
      end
      chk("stall", mem_stall, e_stall);
      chk("access", DAHB_access, e_acc);
      chk("misalign", misalign_err, e_mis);
      chk("rvalid", load_rdata_valid, e_val);
      chk("fault", load_fault, e_flt);
      if (e_val || e_flt) chk("rdata", load_rdata, e_rd);
      if (e_acc) begin
         chk("size", DAHB_size, {1'b0, f3[1:0]});
         chk("rw", DAHB_rd0_wr1, we);
         chk("addr", DAHB_addr, addr);
         chk("wdata", DAHB_write_data, we ? lanes(f3, wd) : 32'h0);
      end
      o_stall = mem_stall; o_access = DAHB_access; o_valid = load_rdata_valid;
      o_fault = load_fault; o_mis = misalign_err; o_rdata = load_rdata;
      o_wdata = DAHB_write_data; o_size = DAHB_size;
      prev_stall = e_stall;
   endtask

   task automatic do_reset();
      @(negedge cpu_clk);
      cpu_reset = 1; mem_req = 0; DAHB_read_data_valid = 0;
      #1;
      chk("rst_stall", mem_stall, 1'b0);
      chk("rst_access", DAHB_access, 1'b0);
      chk("rst_valid", load_rdata_valid, 1'b0);
      chk("rst_fault", load_fault, 1'b0);
      chk("rst_rdata", load_rdata, 32'h0);
      m_load = 0; m_resp = 0; m_rfault = 0; m_wait = 0; prev_stall = 0;
      #2 cpu_reset = 0;
   endtask

   // Load of `delay` wait cycles with data on the last one; reports stall cycles and result.
   task automatic run_load(input bit [2:0] f3, input bit [31:0] addr, input int delay,
                           input bit [31:0] rd, output int stalls, output logic [31:0] res, output bit vld);
      stalls = 0;
      step(1, 0, f3, addr, 0, 0, 0, 0);
      if (o_stall) stalls++;
      for (int i = 1; i <= delay; i++) begin
         step(1, 0, f3, addr, 0, 0, i == delay, rd);
         if (o_stall) stalls++;
      end
      step(1, 0, f3, addr, 0, 0, 0, 0);
      res = o_rdata; vld = o_valid;
   endtask

   bit [2:0]    f3_tab [13] = '{0, 1, 2, 4, 5, 0, 1, 2, 4, 5, 3, 6, 7};
   bit          r_req, r_we;
   bit [2:0]    r_f3;
   bit [31:0]   r_addr, r_wd;

   initial begin
      int          n, acc;
      logic [31:0] res;
      bit          vld;
      cpu_reset = 1; mem_req = 0; mem_we = 0; mem_funct3 = 0; mem_addr = 0; mem_wdata = 0;
      DAHB_trans_buffer_full = 0; DAHB_read_data_valid = 0; DAHB_read_data = 0;
      do_reset();

      step(1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      chk("sw_access", o_access, 1'b1);
      chk("sw_wdata", o_wdata, 32'hDEADBEEF);
      chk("sw_size", o_size, 3'b010);
      chk("sw_stall", o_stall, 1'b0);
      step(1, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0);
      chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
      step(1, 1, 3'b001, 32'h202, 32'h00001234, 0, 0, 0);
      chk("sh_wdata", o_wdata, 32'h12341234);

      run_load(3'b000, 32'h301, 3, 32'h00008000, n, res, vld);
      chk("lb_stalls", n, 4);
      chk("lb_valid", vld, 1'b1);
      chk("lb_rdata", res, 32'hFFFFFF80);
      run_load(3'b100, 32'h301, 3, 32'h00008000, n, res, vld);
      chk("lbu_rdata", res, 32'h00000080);
      run_load(3'b001, 32'h402, 1, 32'h8001_0000, n, res, vld);
      chk("lh_rdata", res, 32'hFFFF8001);

      n = 0; acc = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 3'b010, 32'h500, 32'h0BADF00D, i < 5, 0, 0);
         if (o_stall) n++;
         if (o_access) acc++;
      end
      chk("full_stalls", n, 5);
      chk("full_access", acc, 1);

      step(1, 0, 3'b001, 32'h401, 0, 0, 0, 0);
      chk("lh_mis", {o_mis, o_access, o_stall}, 3'b100);
      step(1, 0, 3'b010, 32'h402, 0, 0, 0, 0);
      chk("lw_mis", {o_mis, o_access, o_stall}, 3'b100);

      step(1, 0, 3'b010, 32'h600, 0, 0, 0, 0);
      n = 0;
      for (int i = 0; i < T; i++) begin
         step(1, 0, 3'b010, 32'h600, 0, 0, 0, 0);
         if (o_stall) n++;
      end
      chk("to_wait", n, T);
      step(1, 0, 3'b010, 32'h600, 0, 0, 0, 0);
      chk("to_fault", {o_fault, o_valid, o_stall}, 3'b100);
      chk("to_rdata", o_rdata, 32'h0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
      chk("stray", {o_valid, o_fault}, 2'b00);

      step(1, 0, 3'b010, 32'h700, 0, 0, 0, 0);
      step(1, 0, 3'b010, 32'h700, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
      chk("rst_stray", {o_valid, o_fault, o_stall}, 3'b000);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         if (!prev_stall) begin
            r_req  = $urandom_range(0, 2) != 0;
            r_we   = $urandom_range(0, 1) == 1;
            r_f3   = f3_tab[$urandom_range(0, 12)];
            r_addr = $urandom;
            r_wd   = $urandom;
         end
         step(r_req, r_we, r_f3, r_addr, r_wd, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dahb_lsu_ctrl.md
Name: dahb_lsu_ctrl

Overview:
Load/store front-end that sits between the core's memory stage and the data AHB master. It converts RISC-V load/store requests into single-cycle transaction-buffer pushes toward the DAHB master, and stalls the pipeline on a full buffer or while a load is outstanding. It replicates store data across byte lanes and extracts and sign- or zero-extends returned load data. It also detects misaligned accesses and times out loads that never return.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width (fixed 32 for lane logic)
TIMEOUT_CYCLES, 1023, max cycles waiting for load data before fault
TMR_WIDTH, 10, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
cpu_clk  in  1  sole clock
cpu_reset  in  1  asynchronous, active-high reset
mem_req  in  1  core memory request; held stable with all fields while mem_stall=1
mem_we  in  1  0 load, 1 store
mem_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_addr  in  ADDR_WIDTH  byte address
mem_wdata  in  DATA_WIDTH  store data, LSB-aligned
mem_stall  out  1  hold core memory stage
load_rdata  out  DATA_WIDTH  extended load result
load_rdata_valid  out  1  one-cycle pulse, load_rdata valid
load_fault  out  1  one-cycle pulse, load timed out
misalign_err  out  1  request misaligned, dropped
DAHB_access  out  1  push one transaction into DAHB buffer
DAHB_size  out  3  AHB HSIZE: 000 byte, 001 half, 010 word
DAHB_rd0_wr1  out  1  read 0 / write 1
DAHB_write_data  out  DATA_WIDTH  lane-replicated store data
DAHB_addr  out  ADDR_WIDTH  = mem_addr, unmodified
DAHB_trans_buffer_full  in  1  buffer full; no push allowed this cycle
DAHB_read_data  in  DATA_WIDTH  raw 32-bit bus read data
DAHB_read_data_valid  in  1  read data valid this cycle

Behaviour:
- Only the clock and reset listed above are used. The reset is asynchronous and active-high.
- Reset values: state IDLE, timer 0, load_rdata 0. All pulse outputs are 0. mem_stall=0, DAHB_access=0.
- Misaligned means funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]!=0.
- Invalid funct3 (011, 11x) is treated as misaligned.
- States: IDLE, WAIT_LOAD, RESP.
- IDLE, no mem_req: all outputs idle.
- IDLE, mem_req and misaligned:
  - misalign_err=1 combinationally; mem_stall=0; DAHB_access=0; stay IDLE.
- IDLE, aligned request, DAHB_trans_buffer_full=1:
  - DAHB_access=0; mem_stall=1; stay IDLE and retry every cycle.
- IDLE, aligned store, not full:
  - DAHB_access=1 the same cycle (combinational); mem_stall=0; stay IDLE.
  - Stores are posted; there are no back-to-back limits.
- IDLE, aligned load, not full:
  - DAHB_access=1 and mem_stall=1.
  - Latch addr[1:0] and funct3; clear the timer; go to WAIT_LOAD.
- WAIT_LOAD:
  - mem_stall=1, DAHB_access=0; timer increments each cycle.
  - On DAHB_read_data_valid: register the extracted data into load_rdata and go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: set the fault flag and go to RESP.
  - If both occur in the same cycle, data wins and there is no fault.
- RESP:
  - mem_stall=0. Assert load_rdata_valid=1, or load_fault=1 with load_rdata=0.
  - No new request is accepted; go to IDLE. The core's held mem_req this cycle is the completed load.
- DAHB_read_data_valid outside WAIT_LOAD is ignored. This covers late data after a fault or after reset.
- Store lanes:
  - SB: wdata[7:0] replicated ×4.
  - SH: wdata[15:0] replicated ×2.
  - SW: wdata passes through unchanged.
- DAHB_write_data=0 for loads. DAHB_rd0_wr1=mem_we.
- DAHB_size is taken from funct3[1:0].
- Load extraction:
  - Byte: DAHB_read_data >> (8·addr[1:0]), then [7:0].
  - Half: DAHB_read_data >> (16·addr[1]), then [15:0].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- Ordering: loads enter the same FIFO behind earlier posted stores, so no bypass logic is needed.
- Reset mid-load: return to IDLE immediately; no pulse is emitted.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, buffer not full -> DAHB_access=1 same cycle, size 010, rd0_wr1=1, write_data 0xDEADBEEF, mem_stall=0.
- SB addr 0x203, wdata 0x000000A5 -> write_data 0xA5A5A5A5, size 000. SH addr 0x202, wdata 0x1234 -> write_data 0x12341234.
- LB addr 0x301, read data 0x0000_80_00 returned 3 cycles later -> stall for 4 cycles, then RESP pulse with load_rdata 0xFFFFFF80. Same with LBU -> 0x00000080.
- Store with DAHB_trans_buffer_full=1 for 5 cycles, then 0 -> mem_stall=1 for 5 cycles, then exactly one DAHB_access pulse.
- LH addr 0x401 -> misalign_err=1, no DAHB_access, no stall. LW addr 0x402 -> same response.
- TIMEOUT_CYCLES=8, LW with no read data -> load_fault pulses after 8 WAIT_LOAD cycles. Stray valid afterward is ignored. Reset during WAIT_LOAD -> IDLE, no pulses.
